// File: rtl/max6675_reader.sv
// Polls two MAX6675 thermocouple converters over a shared SO line and
// publishes each complete 16-bit raw frame with a one-cycle valid strobe.
module max6675_reader #(
  parameter int CLK_DIV   = 25,
  parameter int CONV_WAIT = 11_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_max6675,
  input  logic        max_so,
  output logic        max_sck,
  output logic [1:0]  max_cs_n,
  output logic [15:0] temp_out,
  output logic        temp_valid,
  output logic        open_tc,
  output logic        frame_sel,
  output logic        busy
);

  // state  | meaning
  // WAIT   | conversion gap, CS high, SCK low
  // SETUP  | selected CS low, one SCK half-period before the first edge
  // SHIFT  | 16 SCK periods, SO sampled as SCK rises
  // HOLD   | SCK low, CS still low for one half-period
  // UPDATE | publish the frame for one cycle
  typedef enum logic [2:0] {S_WAIT, S_SETUP, S_SHIFT, S_HOLD, S_UPDATE} state_t;

  localparam int CNT_MAX = (CONV_WAIT > CLK_DIV) ? CONV_WAIT : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WAIT_TC = CW'(CONV_WAIT - 1);
  localparam logic [CW-1:0] DIV_TC  = CW'(CLK_DIV - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      bit_cnt, bit_nxt;
  logic            phase, phase_nxt;
  logic            sel_q, sel_nxt;
  logic            shift_en;
  logic [15:0]     shreg;
  logic [1:0]      cs_n_nxt;
  logic            sck_nxt;
  logic            valid_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      cnt        <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      sel_q      <= 1'b0;
      shreg      <= '0;
      max_cs_n   <= 2'b11;
      max_sck    <= 1'b0;
      temp_valid <= 1'b0;
      temp_out   <= '0;
      open_tc    <= 1'b0;
      frame_sel  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_nxt;
      phase      <= phase_nxt;
      sel_q      <= sel_nxt;
      max_cs_n   <= cs_n_nxt;
      max_sck    <= sck_nxt;
      temp_valid <= valid_nxt;
      if (shift_en)
        shreg <= {shreg[14:0], max_so};
      // Outputs move together with the valid strobe as UPDATE is entered.
      if (state_nxt == S_UPDATE) begin
        temp_out  <= shreg;
        open_tc   <= shreg[2];
        frame_sel <= sel_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_cnt;
    phase_nxt = phase;
    sel_nxt   = sel_q;
    shift_en  = 1'b0;
    case (state)
      S_WAIT: if (cnt == WAIT_TC) begin
        state_nxt = S_SETUP;
        cnt_nxt   = '0;
        sel_nxt   = sel_max6675;
      end
      S_SETUP: if (cnt == DIV_TC) begin
        state_nxt = S_SHIFT;
        cnt_nxt   = '0;
        phase_nxt = 1'b0;
        bit_nxt   = '0;
      end
      S_SHIFT: if (cnt == DIV_TC) begin
        cnt_nxt = '0;
        if (!phase) begin
          phase_nxt = 1'b1;
          shift_en  = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (bit_cnt == 4'd15)
            state_nxt = S_HOLD;
          else
            bit_nxt = bit_cnt + 4'd1;
        end
      end
      S_HOLD: if (cnt == DIV_TC) begin
        state_nxt = S_UPDATE;
        cnt_nxt   = '0;
      end
      S_UPDATE: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    cs_n_nxt = 2'b11;
    if (state_nxt inside {S_SETUP, S_SHIFT, S_HOLD})
      cs_n_nxt = sel_nxt ? 2'b01 : 2'b10;
    sck_nxt   = (state_nxt == S_SHIFT) && phase_nxt;
    valid_nxt = (state_nxt == S_UPDATE);
  end

  assign busy = (max_cs_n != 2'b11);

endmodule
